// File: rtl/packet_deconstructor_pkg.sv
// Shared definitions for the packet/timestamp framer and deconstructor pair.
// Holds the default delimiter, timestamp length and the state encoding both sides use.
package packet_deconstructor_pkg;

   localparam logic [7:0] DEF_SENTINEL    = 8'h00;
   localparam int         DEF_CLOCK_BYTES = 4;

   typedef enum logic [1:0] {
      ST_PACKET   = 2'd0,
      ST_SENTINEL = 2'd1,
      ST_CLOCK    = 2'd2
   } state_e;

   // Width of the timestamp byte index; never narrower than one bit.
   function automatic int idx_width(input int n_bytes);
      if (n_bytes > 1) begin
         return $clog2(n_bytes);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/packet_deconstructor_if.sv
// Byte-stream and timestamp handshake bundle around the packet deconstructor.
// slave is the deconstructor side, master is the UART source / consumer side.
interface packet_deconstructor_if
   import packet_deconstructor_pkg::*;
#(
   parameter int CW = 8 * DEF_CLOCK_BYTES
);
   logic [7:0]    uart_data;
   logic          uart_valid;
   logic          uart_ready;
   logic [7:0]    packet_data;
   logic          packet_valid;
   logic          packet_ready;
   logic          packet_last;
   logic [CW-1:0] clock_data;
   logic          clock_valid;
   logic          clock_ready;
   logic          framing_error;

   modport slave (
      input  uart_data, uart_valid, packet_ready, clock_ready,
      output uart_ready, packet_data, packet_valid, packet_last,
             clock_data, clock_valid, framing_error
   );

   modport master (
      output uart_data, uart_valid, packet_ready, clock_ready,
      input  uart_ready, packet_data, packet_valid, packet_last,
             clock_data, clock_valid, framing_error
   );
endinterface

// File: rtl/packet_deconstructor.sv
// Splits a UART byte stream of payload, sentinel and MSB-first timestamp into a
// last-flagged payload stream and a parallel timestamp word.
module packet_deconstructor
   import packet_deconstructor_pkg::*;
#(
   parameter logic [7:0] SENTINEL    = DEF_SENTINEL,
   parameter int         CLOCK_BYTES = DEF_CLOCK_BYTES
)(
   input logic                    clock,
   input logic                    reset,
   packet_deconstructor_if.slave  bus
);

   localparam int                CW       = 8 * CLOCK_BYTES;
   localparam int                IDX_W    = idx_width(CLOCK_BYTES);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CLOCK_BYTES - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       hold_data_q, hold_data_d;
   logic             hold_full_q, hold_full_d;
   logic [CW-9:0]    shift_q, shift_d;
   logic [7:0]       pkt_data_q, pkt_data_d;
   logic             pkt_valid_q, pkt_valid_d;
   logic             pkt_last_q, pkt_last_d;
   logic [CW-1:0]    clk_data_q, clk_data_d;
   logic             clk_valid_q, clk_valid_d;
   logic             ferr_q, ferr_d;

   logic uart_ready_s, accept_s, pkt_free_s, clk_free_s;
   logic load_pkt_s, load_last_s, load_clk_s;

   assign pkt_free_s = !pkt_valid_q || bus.packet_ready;
   assign clk_free_s = !clk_valid_q || bus.clock_ready;
   assign accept_s   = bus.uart_valid && uart_ready_s;

   // Input backpressure: payload waits on hold+output, only the final timestamp byte waits on the timestamp sink.
   always_comb begin
      uart_ready_s = 1'b0;
      case (state_q)
         ST_PACKET: uart_ready_s = !hold_full_q || pkt_free_s;
         ST_CLOCK: begin
            if (idx_q == LAST_IDX) begin
               uart_ready_s = clk_free_s;
            end else begin
               uart_ready_s = 1'b1;
            end
         end
         default: uart_ready_s = 1'b0;
      endcase
   end

   // Parser next state: hold register, timestamp shifter and load requests.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      hold_data_d = hold_data_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      ferr_d      = 1'b0;
      load_pkt_s  = 1'b0;
      load_last_s = 1'b0;
      load_clk_s  = 1'b0;
      case (state_q)
         ST_PACKET: begin
            if (accept_s) begin
               load_pkt_s = hold_full_q;
               if (bus.uart_data != SENTINEL) begin
                  hold_data_d = bus.uart_data;
                  hold_full_d = 1'b1;
               end else begin
                  // An empty packet still has a timestamp behind it; consume it to stay aligned.
                  load_last_s = 1'b1;
                  hold_full_d = 1'b0;
                  ferr_d      = !hold_full_q;
                  state_d     = ST_CLOCK;
               end
            end else begin
               state_d = ST_PACKET;
            end
         end
         ST_CLOCK: begin
            if (accept_s) begin
               if (idx_q == LAST_IDX) begin
                  load_clk_s = 1'b1;
                  idx_d      = '0;
                  state_d    = ST_PACKET;
               end else begin
                  shift_d = (CW-8)'({shift_q, bus.uart_data});
                  idx_d   = idx_q + IDX_W'(1);
               end
            end else begin
               state_d = ST_CLOCK;
            end
         end
         default: begin
            state_d     = ST_PACKET;
            idx_d       = '0;
            hold_full_d = 1'b0;
         end
      endcase
   end

   // Output registers: a reload and a consumer accept in one cycle chain without a bubble.
   always_comb begin
      pkt_data_d  = pkt_data_q;
      pkt_valid_d = pkt_valid_q;
      pkt_last_d  = pkt_last_q;
      clk_data_d  = clk_data_q;
      clk_valid_d = clk_valid_q;
      if (load_pkt_s) begin
         pkt_data_d  = hold_data_q;
         pkt_valid_d = 1'b1;
         pkt_last_d  = load_last_s;
      end else if (bus.packet_ready) begin
         pkt_valid_d = 1'b0;
         pkt_last_d  = 1'b0;
      end else begin
         pkt_valid_d = pkt_valid_q;
      end
      if (load_clk_s) begin
         clk_data_d  = {shift_q, bus.uart_data};
         clk_valid_d = 1'b1;
      end else if (bus.clock_ready) begin
         clk_valid_d = 1'b0;
      end else begin
         clk_valid_d = clk_valid_q;
      end
   end

   // State and output flops with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_PACKET;
         idx_q       <= '0;
         hold_data_q <= 8'h00;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         pkt_data_q  <= 8'h00;
         pkt_valid_q <= 1'b0;
         pkt_last_q  <= 1'b0;
         clk_data_q  <= '0;
         clk_valid_q <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         hold_data_q <= hold_data_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         pkt_data_q  <= pkt_data_d;
         pkt_valid_q <= pkt_valid_d;
         pkt_last_q  <= pkt_last_d;
         clk_data_q  <= clk_data_d;
         clk_valid_q <= clk_valid_d;
         ferr_q      <= ferr_d;
      end
   end

   assign bus.uart_ready    = uart_ready_s;
   assign bus.packet_data   = pkt_data_q;
   assign bus.packet_valid  = pkt_valid_q;
   assign bus.packet_last   = pkt_last_q;
   assign bus.clock_data    = clk_data_q;
   assign bus.clock_valid   = clk_valid_q;
   assign bus.framing_error = ferr_q;

endmodule

// File: tb/tb_packet_deconstructor.sv
// Bench for packet_deconstructor: a table of whole frames with hand-computed results,
// then hand-written sequences for payload stall, timestamp stall and mid-packet reset.
module tb_packet_deconstructor;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   packet_deconstructor_if #(.CW(32)) ifc ();

   packet_deconstructor dut (
      .clock (clock),
      .reset (reset),
      .bus   (ifc.slave)
   );

   typedef struct packed {
      logic [4:0]   nb;    // stream bytes, right-aligned in b, first byte most significant
      logic [127:0] b;
      logic [3:0]   np;    // expected payload bytes, right-aligned in p
      logic [63:0]  p;
      logic [31:0]  clk;
      logic         fe;
   } vec_t;

   vec_t vecs [5];

   int errors = 0;
   int checks = 0;
   logic pkt_rdy_en;
   logic clk_rdy_en;
   logic [7:0]  pq_data [$];
   logic        pq_last [$];
   logic [31:0] cq [$];
   int ferr_cnt;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Sink side: readiness is set and transfers are recorded on the falling edge.
   initial begin
      ifc.packet_ready = 1'b0;
      ifc.clock_ready  = 1'b0;
      forever begin
         @(negedge clock);
         ifc.packet_ready = pkt_rdy_en;
         ifc.clock_ready  = clk_rdy_en;
         if (ifc.packet_valid && pkt_rdy_en) begin
            pq_data.push_back(ifc.packet_data);
            pq_last.push_back(ifc.packet_last);
         end
         if (ifc.clock_valid && clk_rdy_en) begin
            cq.push_back(ifc.clock_data);
         end
         if (ifc.framing_error) begin
            ferr_cnt++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send(input logic [7:0] b);
      logic rdy;
      bit   done;
      done = 1'b0;
      @(negedge clock);
      ifc.uart_valid = 1'b1;
      ifc.uart_data  = b;
      for (int i = 0; i < 50 && !done; i++) begin
         #1;
         rdy = ifc.uart_ready;
         @(posedge clock);
         if (rdy) done = 1'b1;
         else @(negedge clock);
      end
      chk($sformatf("send_accept_%02h", b), {63'd0, done}, 64'd1);
   endtask

   task automatic drain();
      @(negedge clock);
      ifc.uart_valid = 1'b0;
      repeat (4) @(negedge clock);
      #2;
   endtask

   task automatic clear();
      pq_data.delete();
      pq_last.delete();
      cq.delete();
      ferr_cnt = 0;
   endtask

   task automatic check_out(input string nm, input int np, input logic [63:0] p,
                            input logic [7:0] lm, input int nc, input logic [63:0] c,
                            input int fe);
      chk({nm, "_pkt_count"}, 64'(pq_data.size()), 64'(np));
      for (int i = 0; i < np && i < pq_data.size(); i++) begin
         chk($sformatf("%s_data%0d", nm, i), {56'd0, pq_data[i]}, {56'd0, p[8*(np-1-i) +: 8]});
         chk($sformatf("%s_last%0d", nm, i), {63'd0, pq_last[i]}, {63'd0, lm[np-1-i]});
      end
      chk({nm, "_clk_count"}, 64'(cq.size()), 64'(nc));
      for (int j = 0; j < nc && j < cq.size(); j++) begin
         chk($sformatf("%s_clk%0d", nm, j), {32'd0, cq[j]}, {32'd0, c[32*(nc-1-j) +: 32]});
      end
      chk({nm, "_ferr_cycles"}, 64'(ferr_cnt), 64'(fe));
   endtask

   task automatic set_vec(input int k, input logic [4:0] nb, input logic [127:0] b,
                          input logic [3:0] np, input logic [63:0] p,
                          input logic [31:0] clk, input logic fe);
      vecs[k].nb  = nb;
      vecs[k].b   = b;
      vecs[k].np  = np;
      vecs[k].p   = p;
      vecs[k].clk = clk;
      vecs[k].fe  = fe;
   endtask

   initial begin
      set_vec(0, 5'd8, 128'h41424300DEADBEEF, 4'd3, 64'h414243, 32'hDEADBEEF, 1'b0);
      set_vec(1, 5'd6, 128'h550000000001,     4'd1, 64'h55,     32'h00000001, 1'b0);
      set_vec(2, 5'd7, 128'h10200012345678,   4'd2, 64'h1020,   32'h12345678, 1'b0);
      set_vec(3, 5'd5, 128'h0001020304,       4'd0, 64'h0,      32'h01020304, 1'b1);
      set_vec(4, 5'd6, 128'h9900FF00FF00,     4'd1, 64'h99,     32'hFF00FF00, 1'b0);

      reset          = 1'b0;
      ifc.uart_valid = 1'b0;
      ifc.uart_data  = 8'h00;
      pkt_rdy_en     = 1'b1;
      clk_rdy_en     = 1'b1;
      ferr_cnt       = 0;
      repeat (3) @(negedge clock);
      #1;
      chk("rst_packet_valid",  {63'd0, ifc.packet_valid},  64'd0);
      chk("rst_packet_last",   {63'd0, ifc.packet_last},   64'd0);
      chk("rst_packet_data",   {56'd0, ifc.packet_data},   64'd0);
      chk("rst_clock_valid",   {63'd0, ifc.clock_valid},   64'd0);
      chk("rst_clock_data",    {32'd0, ifc.clock_data},    64'd0);
      chk("rst_framing_error", {63'd0, ifc.framing_error}, 64'd0);
      chk("rst_uart_ready",    {63'd0, ifc.uart_ready},    64'd1);
      @(negedge clock);
      reset = 1'b1;

      for (int k = 0; k < 5; k++) begin
         clear();
         for (int i = 0; i < int'(vecs[k].nb); i++) begin
            send(vecs[k].b[8*(int'(vecs[k].nb)-1-i) +: 8]);
         end
         drain();
         check_out($sformatf("vec%0d", k), int'(vecs[k].np), vecs[k].p, 8'h01,
                   1, {32'd0, vecs[k].clk}, int'(vecs[k].fe));
      end

      // Payload sink stalled: third byte must be refused while hold and output are both full.
      clear();
      pkt_rdy_en = 1'b0;
      send(8'h01);
      send(8'h02);
      @(negedge clock);
      ifc.uart_data = 8'h03;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clock);
         #1;
         chk("stall_uart_ready", {63'd0, ifc.uart_ready}, 64'd0);
         chk("stall_pkt_hold", {55'd0, ifc.packet_valid, ifc.packet_data}, {55'd0, 1'b1, 8'h01});
      end
      pkt_rdy_en = 1'b1;
      send(8'h03); send(8'h04); send(8'h05); send(8'h06); send(8'h00);
      send(8'hC0); send(8'hFF); send(8'hEE); send(8'h00);
      drain();
      check_out("pstall", 6, 64'h010203040506, 8'b00000001, 1, {32'd0, 32'hC0FFEE00}, 0);

      // Timestamp sink stalled across two frames: only the second frame's final byte waits.
      clear();
      clk_rdy_en = 1'b0;
      send(8'h11); send(8'h00); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'h22); send(8'h00); send(8'h05); send(8'h06); send(8'h07);
      @(negedge clock);
      ifc.uart_data = 8'h08;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clock);
         #1;
         chk("cstall_uart_ready", {63'd0, ifc.uart_ready}, 64'd0);
         chk("cstall_clk_hold", {31'd0, ifc.clock_valid, ifc.clock_data}, {31'd0, 1'b1, 32'h01020304});
      end
      clk_rdy_en = 1'b1;
      send(8'h08);
      drain();
      check_out("cstall", 2, 64'h1122, 8'b00000011, 2, {32'h01020304, 32'h05060708}, 0);

      // Reset mid-packet with a held byte and an unaccepted output byte.
      clear();
      pkt_rdy_en = 1'b0;
      send(8'h61);
      send(8'h62);
      @(negedge clock);
      #1;
      chk("pre_rst_pkt", {55'd0, ifc.packet_valid, ifc.packet_data}, {55'd0, 1'b1, 8'h61});
      ifc.uart_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk("mid_rst_packet_valid", {63'd0, ifc.packet_valid}, 64'd0);
      chk("mid_rst_packet_data",  {56'd0, ifc.packet_data},  64'd0);
      chk("mid_rst_packet_last",  {63'd0, ifc.packet_last},  64'd0);
      chk("mid_rst_clock_data",   {32'd0, ifc.clock_data},   64'd0);
      chk("mid_rst_uart_ready",   {63'd0, ifc.uart_ready},   64'd1);
      @(negedge clock);
      reset = 1'b1;
      clear();
      pkt_rdy_en = 1'b1;
      send(8'h70); send(8'h00); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
      drain();
      check_out("rst", 1, 64'h70, 8'h01, 1, {32'd0, 32'hAABBCCDD}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/packet_deconstructor.md
Name: packet_deconstructor

Overview:
- Receive-side counterpart of the packet/timestamp framer.
- Consumes the UART byte stream framed as: payload bytes, then one SENTINEL byte, then CLOCK_BYTES timestamp bytes MSB-first.
- Re-emits the payload as a byte stream with a last flag, and the timestamp as one parallel word.
- Sits between the UART RX byte interface and the packet consumer / timestamp checker.

Parameters:
- SENTINEL, 8'h00, delimiter byte; payload bytes never equal SENTINEL (upstream guarantee); timestamp bytes may.
- CLOCK_BYTES, 4, number of timestamp bytes after the sentinel; clock_data width is 8*CLOCK_BYTES.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- uart_data  input  8  received byte
- uart_valid  input  1  uart_data valid
- uart_ready  output  1  block accepts uart_data this cycle
- packet_data  output  8  payload byte
- packet_valid  output  1  packet_data valid
- packet_ready  input  1  consumer accepts payload byte
- packet_last  output  1  final payload byte of the packet; qualified by packet_valid
- clock_data  output  32  reassembled timestamp (8*CLOCK_BYTES)
- clock_valid  output  1  clock_data valid
- clock_ready  input  1  consumer accepts timestamp
- framing_error  output  1  one-cycle pulse on an empty packet (sentinel with no payload)

Behaviour:
- Handshake rules:
  - A transfer occurs on a cycle where valid && ready are both high.
  - All outputs except uart_ready are registered.
  - An output valid, once high, holds its data stable until accepted.
- Reset (reset==0, asynchronous):
  - state=PACKET, byte index=0, hold register empty.
  - packet_valid=0, packet_last=0, clock_valid=0, framing_error=0.
  - packet_data=0, clock_data=0.
  - A reset mid-packet discards held, partial and pending data.
- One-byte hold register (hold_data, hold_full):
  - The last payload byte is known only when the sentinel arrives, so each byte is buffered until the next byte arrives.
- pkt_free = !packet_valid || packet_ready.
- clk_free = !clock_valid || clock_ready.
- State PACKET:
  - uart_ready = !hold_full || pkt_free.
  - Accepted byte != SENTINEL:
    - If hold_full: hold moves to the output register with last=0.
    - The new byte goes into hold; hold_full=1.
  - Accepted byte == SENTINEL with hold_full:
    - Hold moves to the output with last=1; hold_full=0.
    - Go to CLOCK.
  - Accepted SENTINEL with hold empty:
    - framing_error pulses next cycle; no packet output.
    - Still go to CLOCK to stay aligned with the framer.
- State CLOCK:
  - Bytes are shifted MSB-first into a shift register; no byte value is special.
  - uart_ready = 1 while index < CLOCK_BYTES-1; uart_ready = clk_free on the final byte.
  - On the final byte:
    - clock_data <= {shift[8*CLOCK_BYTES-9:0], uart_data}; clock_valid=1.
    - index=0; go to PACKET.
  - Otherwise index increments on each accepted byte.
- Latency:
  - Payload byte N appears on packet_data 1 cycle after byte N+1 (or the sentinel) is accepted.
  - The timestamp appears 1 cycle after its last byte is accepted.
- Simultaneous events:
  - A consumer accept and a reload in the same cycle give back-to-back output with no bubble.
  - A clock_valid still pending when the next packet's payload arrives does not stall payload; only the final timestamp byte of the next frame waits on clk_free.
- packet_valid and clock_valid are independent; a new timestamp never overwrites an unaccepted one.

Decomposition:
- Shared package/header with the framer:
  - SENTINEL and CLOCK_BYTES defaults.
  - State encodings PACKET/SENTINEL/CLOCK.
  - Byte-index width clog2(CLOCK_BYTES).
- Single module; no sub-module warranted (the hold register and the output register are a few lines each).

Test Plan:
- Stream 41 42 43 00 DE AD BE EF, sinks always ready -> packet 41,42,43 with last only on 43; clock_data=32'hDEADBEEF; framing_error stays 0.
- Timestamp containing sentinel values: 55 00 00 00 00 01 -> single packet byte 55 with last=1; clock_data=32'h00000001; second frame parses cleanly.
- packet_ready held low for 5 cycles mid-packet -> uart_ready drops once hold and output are both full; no byte lost or duplicated; order preserved.
- clock_ready low across two back-to-back frames -> second frame's final timestamp byte stalled (uart_ready=0) until the first timestamp is accepted; both values correct.
- Empty frame 00 01 02 03 04 -> framing_error one-cycle pulse; no packet_valid; clock_data=32'h01020304.
- reset driven low after 61 62 mid-packet, then 70 00 AA BB CC DD -> outputs clear asynchronously; packet is 70 only, last=1; clock_data=32'hAABBCCDD.
